// File: rtl/ramp_adc_pkg.sv
// Shared types and constants for the ramp-compare ADC controller.
// Holds the FSM state encoding, the default result width and a helper
// that gives the number of clk cycles each duty step is held.
package ramp_adc_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } adc_state_t;

  // Cycles per duty step: SETTLE_PERIODS full PWM periods of 2**DATA_W clocks.
  function automatic int step_len(input int data_w, input int settle_periods);
    return settle_periods * (2 ** data_w);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Single-bit edge detector with a synchronous active-high reset.
// FALLING=1 flags 1->0 transitions, FALLING=0 flags 0->1 transitions.
// The pulse is combinational from the delayed copy and the live input,
// so it is high during the cycle right after din changes.
module edge_detector #(
  parameter bit FALLING = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic din_d_reg;

  // Delay line; resets to the idle level so no edge is reported out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_d_reg <= FALLING;
    end else begin
      din_d_reg <= din;
    end
  end

  assign pulse = FALLING ? (din_d_reg & ~din) : (~din_d_reg & din);

endmodule

// File: rtl/ramp_adc_controller.sv
// Ramp-compare ADC sequencer. Steps a PWM duty from 0 to full scale, samples
// the synchronized comparator only at the end of each settled step, and
// captures the duty code at which the comparator falls. The result is
// offered on a valid/ready interface.
// Optional macro RAMP_ADC_CONT_MODE_EN: after each accepted result a new
// conversion starts immediately, without waiting for another start pulse.
module ramp_adc_controller
  import ramp_adc_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int SETTLE_PERIODS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cmp_in,
  output logic              pwm_out,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              over_range,
  output logic              data_valid,
  input  logic              data_ready
);

  localparam int                PW          = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
  localparam logic [DATA_W-1:0] FULL        = {DATA_W{1'b1}};
  localparam logic [PW-1:0]     LAST_PERIOD = PW'(SETTLE_PERIODS - 1);

  adc_state_t         state_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [DATA_W-1:0]  pwm_cnt_reg;
  logic [PW-1:0]      period_cnt_reg;
  logic [DATA_W-1:0]  duty_reg;
  logic [DATA_W-1:0]  step_duty_reg;
  logic               last_step_reg;
  logic               cmp_q_reg;
  logic               cmp_sync;
  logic               trip;
  logic               step_end;

  // Comparator synchronizer; idles high (ramp below input).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_reg <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], cmp_in};
    end
  end

  assign cmp_sync = sync_reg[SYNC_STAGES-1];
  assign step_end = (state_reg == RAMP) && (pwm_cnt_reg == FULL) &&
                    (period_cnt_reg == LAST_PERIOD);

  // Trip pulse: the sampled comparator fell at the last step end.
  edge_detector #(
    .FALLING(1'b1)
  ) u_trip_edge (
    .clk  (clk),
    .reset(~reset_n),
    .din  (cmp_q_reg),
    .pulse(trip)
  );

  // Conversion FSM with counters, duty stepping and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      pwm_cnt_reg    <= '0;
      period_cnt_reg <= '0;
      duty_reg       <= '0;
      step_duty_reg  <= '0;
      last_step_reg  <= 1'b0;
      cmp_q_reg      <= 1'b1;
      pwm_out        <= 1'b0;
      busy           <= 1'b0;
      data_out       <= '0;
      over_range     <= 1'b0;
      data_valid     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          pwm_out <= 1'b0;
          if (start) begin
            duty_reg       <= '0;
            pwm_cnt_reg    <= '0;
            period_cnt_reg <= '0;
            last_step_reg  <= 1'b0;
            cmp_q_reg      <= 1'b1;
            busy           <= 1'b1;
            state_reg      <= RAMP;
          end
        end
        RAMP: begin
          pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
          pwm_out     <= (pwm_cnt_reg < duty_reg);
          if (pwm_cnt_reg == FULL) begin
            period_cnt_reg <= period_cnt_reg + 1'b1;
          end
          if (trip) begin
            // Report the duty that was held while the comparator was sampled.
            data_out   <= step_duty_reg;
            over_range <= 1'b0;
            data_valid <= 1'b1;
            pwm_out    <= 1'b0;
            state_reg  <= DONE;
          end else if (last_step_reg) begin
            // Full-scale step sampled without a trip: input above range.
            data_out   <= FULL;
            over_range <= 1'b1;
            data_valid <= 1'b1;
            pwm_out    <= 1'b0;
            state_reg  <= DONE;
          end else if (step_end) begin
            cmp_q_reg      <= cmp_sync;
            step_duty_reg  <= duty_reg;
            period_cnt_reg <= '0;
            if (duty_reg == FULL) begin
              last_step_reg <= 1'b1;
            end else begin
              duty_reg <= duty_reg + 1'b1;
            end
          end
        end
        DONE: begin
          pwm_out <= 1'b0;
          if (data_ready) begin
            data_valid <= 1'b0;
`ifdef RAMP_ADC_CONT_MODE_EN
            duty_reg       <= '0;
            pwm_cnt_reg    <= '0;
            period_cnt_reg <= '0;
            last_step_reg  <= 1'b0;
            cmp_q_reg      <= 1'b1;
            state_reg      <= RAMP;
`else
            busy      <= 1'b0;
            state_reg <= IDLE;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramp_adc_controller.sv
// Directed self-checking bench for ramp_adc_controller with DATA_W=4,
// SETTLE_PERIODS=2 (32 clk cycles per duty step).
module tb_ramp_adc_controller;
  import ramp_adc_pkg::*;

  localparam int DW      = 4;
  localparam int SP      = 2;
  localparam int STEP    = step_len(DW, SP);
  localparam int TIMEOUT = 1000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          cmp_in;
  logic          pwm_out;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          over_range;
  logic          data_valid;
  logic          data_ready;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ramp_adc_controller #(
    .DATA_W        (DW),
    .SETTLE_PERIODS(SP),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .cmp_in    (cmp_in),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .data_out  (data_out),
    .over_range(over_range),
    .data_valid(data_valid),
    .data_ready(data_ready)
  );

  task automatic do_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    data_ready = 1'b0;
    cmp_in     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Starts a conversion and waits for data_valid. fall_at: edge count after
  // the start edge at which cmp_in drops (0 = low before start, <0 = never).
  // glitch_at: edge count for a 3-cycle low glitch (<0 = none). A start
  // pulse is also injected mid-ramp, which must be ignored.
  task automatic convert(input int fall_at, input int glitch_at,
                         output logic [DW-1:0] code, output logic ovr,
                         output int lat, output int max_high, output bit timed_out);
    logic [15:0] hist;
    int h;
    hist      = '0;
    max_high  = 0;
    lat       = 0;
    timed_out = 1'b1;
    cmp_in     = (fall_at == 0) ? 1'b0 : 1'b1;
    data_ready = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(posedge clk);
      #1;
      hist = {hist[14:0], pwm_out};
      h = $countones(hist);
      if (h > max_high) max_high = h;
      if (n == fall_at) cmp_in = 1'b0;
      if (glitch_at > 0 && n == glitch_at) cmp_in = 1'b0;
      if (glitch_at > 0 && n == glitch_at + 3) cmp_in = 1'b1;
      if (n == 50) start = 1'b1;
      if (n == 51) start = 1'b0;
      if (data_valid) begin
        lat = n;
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    code  = data_out;
    ovr   = over_range;
  endtask

  task automatic handshake();
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pwm_out, busy, data_valid, over_range} !== 4'b0000 || data_out !== 4'd0) begin
      fails++;
      $display("FAIL reset_outputs: pwm=%b busy=%b valid=%b ovr=%b data=%0d, required all 0",
               pwm_out, busy, data_valid, over_range, data_out);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: valid=%b busy=%b, required 0 0", data_valid, busy);
    end
    $display("test_reset: outputs after reset checked");
  endtask

  task automatic test_mid_code();
    logic [DW-1:0] code; logic ovr; int lat; int mh; bit to;
    do_reset();
    convert(5 * STEP + 10, -1, code, ovr, lat, mh, to);
    $display("test_mid_code: code=%0d ovr=%b latency=%0d max_pwm_high=%0d", code, ovr, lat, mh);
    checks++;
    if (to) begin fails++; $display("FAIL mid_timeout: no data_valid within %0d cycles", TIMEOUT); end
    checks++;
    if (code !== 4'd5 || ovr !== 1'b0) begin
      fails++; $display("FAIL mid_code: got code=%0d ovr=%b, required 5 0", code, ovr);
    end
    checks++;
    if (lat < 6 * STEP || lat > 6 * STEP + 3) begin
      fails++; $display("FAIL mid_latency: got %0d, required %0d..%0d", lat, 6 * STEP, 6 * STEP + 3);
    end
    checks++;
    if (mh !== 5) begin fails++; $display("FAIL mid_pwm_duty: got %0d/16, required 5/16", mh); end
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b, required 1", busy); end
    handshake();
  endtask

  task automatic test_low_at_start();
    logic [DW-1:0] code; logic ovr; int lat; int mh; bit to;
    do_reset();
    convert(0, -1, code, ovr, lat, mh, to);
    $display("test_low_at_start: code=%0d ovr=%b latency=%0d", code, ovr, lat);
    checks++;
    if (to || code !== 4'd0 || ovr !== 1'b0) begin
      fails++; $display("FAIL low_code: got code=%0d ovr=%b timeout=%0d, required 0 0 0", code, ovr, to);
    end
    checks++;
    if (lat < STEP || lat > STEP + 3) begin
      fails++; $display("FAIL low_latency: got %0d, required %0d..%0d", lat, STEP, STEP + 3);
    end
    checks++;
    if (mh !== 0) begin fails++; $display("FAIL low_pwm_duty: got %0d/16, required 0/16", mh); end
    handshake();
  endtask

  // Leaves the result pending (no handshake) for test_hold.
  task automatic test_over_range();
    logic [DW-1:0] code; logic ovr; int lat; int mh; bit to;
    do_reset();
    convert(-1, -1, code, ovr, lat, mh, to);
    $display("test_over_range: code=%0d ovr=%b latency=%0d max_pwm_high=%0d", code, ovr, lat, mh);
    checks++;
    if (to || code !== 4'd15 || ovr !== 1'b1) begin
      fails++; $display("FAIL over_code: got code=%0d ovr=%b timeout=%0d, required 15 1 0", code, ovr, to);
    end
    checks++;
    if (mh !== 15) begin fails++; $display("FAIL over_pwm_duty: got %0d/16, required 15/16", mh); end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      start = (i % 10 == 3);
      @(posedge clk);
      #1;
      checks++;
      if (data_valid !== 1'b1 || data_out !== 4'd15 || over_range !== 1'b1 || busy !== 1'b1) begin
        fails++; bad++;
        if (bad <= 3)
          $display("FAIL hold_stable: cycle %0d valid=%b data=%0d ovr=%b busy=%b, required 1 15 1 1",
                   i, data_valid, data_out, over_range, busy);
      end
    end
    start = 1'b0;
    $display("test_hold: 50 stall cycles checked, %0d bad", bad);
    handshake();
    checks++;
`ifdef RAMP_ADC_CONT_MODE_EN
    if (data_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL hold_release: valid=%b busy=%b, required 0 1", data_valid, busy);
    end
`else
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL hold_release: valid=%b busy=%b, required 0 0", data_valid, busy);
    end
`endif
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (data_valid !== 1'b0 || pwm_out !== 1'b0) begin
      fails++; $display("FAIL hold_no_queue: valid=%b pwm=%b, required 0 0", data_valid, pwm_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] code; logic ovr; int lat; int mh; bit to;
    do_reset();
    cmp_in = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7 * STEP + 5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b, required 1", busy); end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checks++;
    if ({pwm_out, busy, data_valid, over_range} !== 4'b0000 || data_out !== 4'd0) begin
      fails++;
      $display("FAIL rmid_outputs: pwm=%b busy=%b valid=%b ovr=%b data=%0d, required all 0",
               pwm_out, busy, data_valid, over_range, data_out);
    end
    convert(0, -1, code, ovr, lat, mh, to);
    $display("test_reset_mid: restart code=%0d latency=%0d", code, lat);
    checks++;
    if (to || code !== 4'd0 || lat > STEP + 3) begin
      fails++; $display("FAIL rmid_restart: got code=%0d latency=%0d, required 0 within %0d", code, lat, STEP + 3);
    end
    handshake();
  endtask

  task automatic test_glitch();
    logic [DW-1:0] code; logic ovr; int lat; int mh; bit to;
    do_reset();
    convert(9 * STEP + 5, 2 * STEP + 10, code, ovr, lat, mh, to);
    $display("test_glitch: code=%0d ovr=%b latency=%0d", code, ovr, lat);
    checks++;
    if (to || code !== 4'd9 || ovr !== 1'b0) begin
      fails++; $display("FAIL glitch_code: got code=%0d ovr=%b timeout=%0d, required 9 0 0", code, ovr, to);
    end
    handshake();
  endtask

`ifdef RAMP_ADC_CONT_MODE_EN
  task automatic test_back_to_back();
    int n;
    do_reset();
    cmp_in = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n = 0;
      while (!data_valid && n < TIMEOUT) begin
        @(posedge clk);
        #1;
        n++;
      end
      $display("test_back_to_back: conversion %0d code=%0d wait=%0d", c, data_out, n);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 4'd0 || busy !== 1'b1) begin
        fails++; $display("FAIL b2b_code: conv %0d valid=%b data=%0d busy=%b, required 1 0 1",
                          c, data_valid, data_out, busy);
      end
      handshake();
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_mid_code();
    test_low_at_start();
    test_over_range();
    test_hold();
    test_reset_mid();
    test_glitch();
`ifdef RAMP_ADC_CONT_MODE_EN
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
